// File: rtl/ch_role_writer_pkg.sv
// ch_role_writer_pkg: shared memory map, flag bit positions and FSM encoding for the CH role writer/checker
package ch_role_writer_pkg;

    localparam int MEM_DEPTH  = 2048;
    localparam int MEM_WIDTH  = 16;
    localparam int WORD_WIDTH = 16;
    localparam int ADDR_WIDTH = 11;

    localparam logic [ADDR_WIDTH-1:0] FLAGS_ADDR = 11'h001;
    localparam logic [ADDR_WIDTH-1:0] CHID_ADDR  = 11'h002;

    localparam int ROLE_BIT = 7;
    localparam int AGG_BIT  = 6;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_WAIT = 3'd1,
        S_MODIFY  = 3'd2,
        S_WR_FLG  = 3'd3,
        S_WR_CHID = 3'd4,
        S_WR_END  = 3'd5,
        S_DONE    = 3'd6,
        S_HOLD    = 3'd7
    } state_t;

endpackage

// File: rtl/ch_role_writer.sv
// ch_role_writer: commits the cluster-head election result (role flag + CH ID) into node memory
//  clock    in   system clock, rising edge
//  nrst     in   asynchronous active-low reset
//  en       in   re-arm from HOLD back to IDLE
//  start    in   begin a commit (sampled in IDLE only)
//  is_ch    in   election result, captured at start
//  ch_id    in   elected CH node ID, captured at start
//  data_in  in   memory read data, valid one cycle after address
//  address  out  memory address
//  data_out out  memory write data
//  wr_en    out  memory write strobe
//  done     out  commit complete, held in HOLD
module ch_role_writer
    import ch_role_writer_pkg::*;
(
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  en,
    input  logic                  start,
    input  logic                  is_ch,
    input  logic [WORD_WIDTH-1:0] ch_id,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  wr_en,
    output logic                  done
);

    // Role bit takes the election result; forAggregation is always cleared so the
    // role checker recomputes it from a clean state.
    function automatic logic [WORD_WIDTH-1:0] merge_flags(
        input logic [WORD_WIDTH-1:0] flags,
        input logic                  role
    );
        logic [WORD_WIDTH-1:0] m;
        m           = flags;
        m[ROLE_BIT] = role;
        m[AGG_BIT]  = 1'b0;
        return m;
    endfunction

    state_t                state, state_nx;
    logic                  is_ch_r;
    logic [WORD_WIDTH-1:0] ch_id_r;
    logic [ADDR_WIDTH-1:0] address_nx;
    logic [WORD_WIDTH-1:0] data_out_nx;
    logic                  wr_en_nx, done_nx;

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state    <= S_IDLE;
            is_ch_r  <= 1'b0;
            ch_id_r  <= '0;
            address  <= '0;
            data_out <= '0;
            wr_en    <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            address  <= address_nx;
            data_out <= data_out_nx;
            wr_en    <= wr_en_nx;
            done     <= done_nx;
            if (state == S_IDLE && start) begin
                is_ch_r <= is_ch;
                ch_id_r <= ch_id;
            end
        end
    end

    always_comb begin
        state_nx = S_IDLE;
        case (state)
            S_IDLE:    state_nx = start ? S_RD_WAIT : S_IDLE;
            S_RD_WAIT: state_nx = S_MODIFY;
            S_MODIFY:  state_nx = S_WR_FLG;
            S_WR_FLG:  state_nx = S_WR_CHID;
            S_WR_CHID: state_nx = S_WR_END;
            S_WR_END:  state_nx = S_DONE;
            S_DONE:    state_nx = S_HOLD;
            S_HOLD:    state_nx = en ? S_IDLE : S_HOLD;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Outputs are registered, so each branch sets what the outputs become on
    // entry to the next state: the merged flags word is loaded straight into
    // data_out while leaving MODIFY so the write strobe lines up with WR_FLG.
    always_comb begin
        address_nx  = address;
        data_out_nx = data_out;
        wr_en_nx    = 1'b0;
        done_nx     = done;
        case (state)
            S_IDLE:    address_nx = start ? FLAGS_ADDR : address;
            S_MODIFY: begin
                address_nx  = FLAGS_ADDR;
                data_out_nx = merge_flags(data_in, is_ch_r);
                wr_en_nx    = 1'b1;
            end
            S_WR_FLG: begin
                address_nx  = CHID_ADDR;
                data_out_nx = ch_id_r;
                wr_en_nx    = 1'b1;
            end
            S_DONE:    done_nx = 1'b1;
            S_HOLD: begin
                address_nx  = en ? FLAGS_ADDR : address;
                data_out_nx = en ? '0 : data_out;
                done_nx     = !en;
            end
            default:   wr_en_nx = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ch_role_writer.sv
// tb_ch_role_writer: scoreboard bench for ch_role_writer with a 2048x16 registered-read memory model
module tb_ch_role_writer;

    localparam logic [10:0] FA = 11'h001;
    localparam logic [10:0] CA = 11'h002;

    logic        clock = 1'b0;
    logic        nrst = 1'b0;
    logic        en = 1'b0;
    logic        start = 1'b0;
    logic        is_ch = 1'b0;
    logic [15:0] ch_id = '0;
    logic [15:0] data_in;
    logic [10:0] address;
    logic [15:0] data_out;
    logic        wr_en;
    logic        done;

    logic [15:0] mem [0:2047];
    logic        pl_en = 1'b0;
    logic [10:0] pl_addr = '0;
    logic [15:0] pl_data = '0;

    logic [26:0] exp_q [$];
    int n_checks = 0;
    int n_fail = 0;
    int wr_cnt = 0;

    always #5 clock = ~clock;

    ch_role_writer dut (
        .clock(clock), .nrst(nrst), .en(en), .start(start), .is_ch(is_ch),
        .ch_id(ch_id), .data_in(data_in), .address(address),
        .data_out(data_out), .wr_en(wr_en), .done(done)
    );

    always @(posedge clock) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (wr_en) mem[address] <= data_out;
        data_in <= mem[address];
    end

    always @(posedge clock) begin
        logic [26:0] e;
        if (nrst && wr_en) begin
            wr_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL extra_write: got addr=%h data=%h, required no write", address, data_out);
            end else begin
                e = exp_q.pop_front();
                if ({address, data_out} !== e) begin
                    n_fail++;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             address, data_out, e[26:16], e[15:0]);
                end
            end
        end
    end

    task automatic preload(input logic [10:0] a, input logic [15:0] d);
        @(negedge clock);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clock);
        pl_en = 1'b0;
    endtask

    // Starts at a negedge with the DUT in IDLE; returns at the negedge after done rises.
    task automatic commit(input logic [15:0] flags, input logic ic, input logic [15:0] id,
                          input bit pre, input bit toggle);
        logic [15:0] exp_f;
        int w0;
        if (pre) begin
            preload(FA, flags);
            preload(CA, 16'hBEEF);
        end
        exp_f = (flags & 16'hFF3F) | (ic ? 16'h0080 : 16'h0000);
        w0 = wr_cnt;
        start = 1'b1; is_ch = ic; ch_id = id;
        exp_q.push_back({FA, exp_f});
        exp_q.push_back({CA, id});
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (toggle && k == 2) begin
                start = 1'b1; is_ch = ~ic; ch_id = ~id;
            end
            if (toggle && k == 4) start = 1'b0;
            n_checks++;
            if (done !== (k == 6)) begin
                n_fail++;
                $display("FAIL done_timing: edge N+%0d done=%b, required %b", k, done, k == 6);
            end
        end
        n_checks++;
        if (mem[1] !== exp_f) begin
            n_fail++;
            $display("FAIL flags_word: mem[1]=%h, required %h", mem[1], exp_f);
        end
        n_checks++;
        if (mem[2] !== id) begin
            n_fail++;
            $display("FAIL chid_word: mem[2]=%h, required %h", mem[2], id);
        end
        n_checks++;
        if (wr_cnt - w0 != 2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL write_count: %0d writes, %0d pending, required 2 writes 0 pending",
                     wr_cnt - w0, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic rearm();
        @(negedge clock);
        en = 1'b1;
        @(posedge clock);
        @(negedge clock);
        en = 1'b0;
        n_checks++;
        if (done !== 1'b0 || data_out !== 16'h0 || address !== FA || wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rearm: done=%b data_out=%h address=%h wr_en=%b, required 0 0000 001 0",
                     done, data_out, address, wr_en);
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (address !== 11'h0 || data_out !== 16'h0 || wr_en !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: address=%h data_out=%h wr_en=%b done=%b, required all 0",
                     address, data_out, wr_en, done);
        end
        @(negedge clock);
        nrst = 1'b1;
    endtask

    task automatic test_commit_ch();
        commit(16'h0041, 1'b1, 16'h0007, 1'b1, 1'b0);
        rearm();
    endtask

    task automatic test_commit_member();
        commit(16'h00C3, 1'b0, 16'h0012, 1'b1, 1'b0);
        rearm();
    endtask

    task automatic test_ignore_inputs();
        commit(16'h1234, 1'b1, 16'h0abc, 1'b1, 1'b1);
        is_ch = 1'b0; ch_id = '0;
        rearm();
    endtask

    task automatic test_reset_mid();
        preload(FA, 16'h0041);
        preload(CA, 16'h5A5A);
        start = 1'b1; is_ch = 1'b1; ch_id = 16'h0033;
        exp_q.push_back({FA, 16'h0081});
        exp_q.push_back({CA, 16'h0033});
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clock);
            @(negedge clock);
        end
        n_checks++;
        if (wr_en !== 1'b1 || address !== CA) begin
            n_fail++;
            $display("FAIL wr_chid_state: wr_en=%b address=%h, required 1 002", wr_en, address);
        end
        #2 nrst = 1'b0;
        #1;
        n_checks++;
        if (wr_en !== 1'b0 || done !== 1'b0 || address !== 11'h0) begin
            n_fail++;
            $display("FAIL async_reset: wr_en=%b done=%b address=%h, required 0 0 000",
                     wr_en, done, address);
        end
        exp_q.delete();
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        n_checks++;
        if (mem[1] !== 16'h0081 || mem[2] !== 16'h5A5A) begin
            n_fail++;
            $display("FAIL abort_mem: mem[1]=%h mem[2]=%h, required 0081 5a5a", mem[1], mem[2]);
        end
        nrst = 1'b1;
        @(negedge clock);
        commit(16'h0080, 1'b0, 16'h0044, 1'b1, 1'b0);
        rearm();
    endtask

    task automatic test_hold();
        commit(16'hFFFF, 1'b1, 16'h00A5, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            n_checks++;
            if (done !== 1'b1 || wr_en !== 1'b0) begin
                n_fail++;
                $display("FAIL hold: cycle %0d done=%b wr_en=%b, required 1 0", i, done, wr_en);
            end
        end
        rearm();
        commit(16'h0000, 1'b1, 16'h0101, 1'b1, 1'b0);
    endtask

    task automatic test_start_en_hold();
        int w0;
        preload(FA, 16'h00C0);
        preload(CA, 16'h7777);
        w0 = wr_cnt;
        start = 1'b1; en = 1'b1; is_ch = 1'b1; ch_id = 16'h0099;
        @(posedge clock);
        @(negedge clock);
        en = 1'b0;
        n_checks++;
        if (done !== 1'b0 || address !== FA || wr_cnt != w0 || mem[2] !== 16'h7777) begin
            n_fail++;
            $display("FAIL start_en_hold: done=%b address=%h writes=%0d mem[2]=%h, required 0 001 0 7777",
                     done, address, wr_cnt - w0, mem[2]);
        end
        commit(16'h00C0, 1'b1, 16'h0099, 1'b0, 1'b0);
        rearm();
    endtask

    initial begin
        test_reset();
        test_commit_ch();
        test_commit_member();
        test_ignore_inputs();
        test_reset_mid();
        test_hold();
        test_start_en_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, required completion");
        $fatal(1);
    end

endmodule
